// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a registered
// borrow, LSB-first, one bit per clock, with a single-cycle done pulse.
module subtrator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, diff_bit}.
    function automatic logic [1:0] fs_cell(input logic x, input logic y, input logic bin);
        logic d_bit;
        logic b_bit;
        d_bit = x ^ y ^ bin;
        b_bit = (~x & y) | (~(x ^ y) & bin);
        return {b_bit, d_bit};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, b_sr_q, work_q, diff_q;
    logic               br_q, borrow_out_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, busy_d, done_q, done_d;
    logic [1:0]         cell_res;
    logic [WIDTH-1:0]   work_next;
    logic               last_bit;
    logic               accept;

    assign cell_res  = fs_cell(a_sr_q[0], b_sr_q[0], br_q);
    assign work_next = {cell_res[0], work_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept    = (state_q == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_IDLE:  begin busy_d = 1'b0; done_d = 1'b0; end
            ST_SHIFT: begin busy_d = 1'b1; done_d = 1'b0; end
            ST_DONE:  begin busy_d = 1'b0; done_d = 1'b1; end
            default:  begin busy_d = 1'b0; done_d = 1'b0; end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Serial datapath; results are only committed on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q       <= {WIDTH{1'b0}};
            b_sr_q       <= {WIDTH{1'b0}};
            work_q       <= {WIDTH{1'b0}};
            br_q         <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
        end else if (accept) begin
            a_sr_q <= a;
            b_sr_q <= b;
            br_q   <= borrow_in;
            cnt_q  <= {CNT_W{1'b0}};
        end else if (state_q == ST_SHIFT) begin
            a_sr_q <= a_sr_q >> 1;
            b_sr_q <= b_sr_q >> 1;
            br_q   <= cell_res[1];
            work_q <= work_next;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                diff_q       <= work_next;
                borrow_out_q <= cell_res[1];
            end else begin
                diff_q       <= diff_q;
                borrow_out_q <= borrow_out_q;
            end
        end else begin
            a_sr_q <= a_sr_q;
            b_sr_q <= b_sr_q;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Randomized and directed bench for subtrator_serial at WIDTH 8, 4 and 2,
// checked against a plain-arithmetic reference model.
module tb_subtrator_serial;

    logic clk;
    logic rst_n;

    logic       start8, bin8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bo4;
    logic [3:0] a4, b4, diff4;
    logic       start2, bin2, busy2, done2, bo2;
    logic [1:0] a2, b2, diff2;

    int n_cmp = 0;
    int n_err = 0;

    subtrator_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
    subtrator_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4));
    subtrator_serial #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .borrow_in(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a - b - bin as a signed integer, folded into w bits.
    function automatic int ref_diff(input int x, input int y, input int bi, input int w);
        int r;
        r = x - y - bi + (1 << (w + 1));
        return r % (1 << w);
    endfunction

    function automatic int ref_bout(input int x, input int y, input int bi);
        return ((x - y - bi) < 0) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one WIDTH=8 op from IDLE and wait for done (no checking here).
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                           output int lat, output int busy_n, output logic early,
                           output logic timed_out);
        logic [7:0] d0;
        logic       b0;
        d0 = diff8;
        b0 = bo8;
        a8 = ta; b8 = tb_v; bin8 = tbin; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        lat = 0; busy_n = 0; early = 1'b0; timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done8) begin
                timed_out = 1'b0;
                break;
            end
            if (busy8) busy_n++;
            if (diff8 !== d0 || bo8 !== b0) early = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        start2 = 1'b0; a2 = 2'b00; b2 = 2'b00; bin2 = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({busy8, done8, diff8, bo8} !== 11'h000) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bo8);
        end
        n_cmp++;
        if ({busy4, done4, diff4, bo4, busy2, done2, diff2, bo2} !== 14'h0000) begin
            n_err++;
            $display("FAIL reset4_2: got diff4=%h diff2=%b, want all outputs 0", diff4, diff2);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, busy_n;
        logic early, to;
        run_op8(8'h05, 8'h00, 1'b0, lat, busy_n, early, to);
        n_cmp++;
        if (to || lat != 8) begin
            n_err++;
            $display("FAIL basic_latency: got %0d (timeout=%b), want 8", lat, to);
        end
        n_cmp++;
        if (busy_n != 8) begin
            n_err++;
            $display("FAIL basic_busy: got %0d busy cycles, want 8", busy_n);
        end
        n_cmp++;
        if (diff8 !== 8'h05 || bo8 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got %h/%b, want 05/0", diff8, bo8);
        end
        n_cmp++;
        if (early) begin
            n_err++;
            $display("FAIL basic_stable: got early output change, want none before done");
        end
        tick();
        n_cmp++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse: got done=%b busy=%b after pulse, want 0/0", done8, busy8);
        end
    endtask

    task automatic test_borrow();
        int lat, busy_n;
        logic early, to;
        run_op8(8'h00, 8'h01, 1'b0, lat, busy_n, early, to);
        n_cmp++;
        if (to || diff8 !== 8'hFF || bo8 !== 1'b1) begin
            n_err++;
            $display("FAIL borrow_0m1: got %h/%b, want ff/1", diff8, bo8);
        end
        tick();
        run_op8(8'h00, 8'hFF, 1'b1, lat, busy_n, early, to);
        n_cmp++;
        if (to || diff8 !== 8'h00 || bo8 !== 1'b1) begin
            n_err++;
            $display("FAIL borrow_0mff1: got %h/%b, want 00/1", diff8, bo8);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [7:0] got_d;
        logic got_b;
        dones = 0; got_d = 8'h00; got_b = 1'b0;
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done8) begin
                dones++;
                got_d = diff8;
                got_b = bo8;
            end
            tick();
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL ignore_dones: got %0d done pulses, want 1", dones);
        end
        n_cmp++;
        if (got_d !== 8'h7E || got_b !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result: got %h/%b, want 7e/0", got_d, got_b);
        end
        n_cmp++;
        if (busy8 !== 1'b0 || diff8 !== 8'h7E) begin
            n_err++;
            $display("FAIL ignore_idle: got busy=%b diff=%h, want 0/7e", busy8, diff8);
        end
    endtask

    task automatic test_reset_mid_shift();
        int dones, lat, busy_n;
        logic early, to;
        dones = 0;
        a8 = 8'h3C; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, done8, diff8, bo8} !== 11'h000) begin
            n_err++;
            $display("FAIL midreset_clear: got busy=%b done=%b diff=%h bout=%b, want all 0", busy8, done8, diff8, bo8);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) dones++;
            tick();
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL midreset_nodone: got %0d active cycles, want 0", dones);
        end
        run_op8(8'h3C, 8'h0F, 1'b0, lat, busy_n, early, to);
        n_cmp++;
        if (to || diff8 !== 8'h2D || bo8 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_redo: got %h/%b, want 2d/0", diff8, bo8);
        end
        tick();
    endtask

    task automatic test_random8();
        int lat, busy_n, ra, rb, rbi;
        logic early, to;
        logic [7:0] exp_d;
        logic exp_b;
        for (int n = 0; n < 25; n++) begin
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            rbi = int'($urandom_range(1, 0));
            exp_d = 8'(ref_diff(ra, rb, rbi, 8));
            exp_b = 1'(ref_bout(ra, rb, rbi));
            run_op8(8'(ra), 8'(rb), 1'(rbi), lat, busy_n, early, to);
            n_cmp++;
            if (to || lat != 8 || early || diff8 !== exp_d || bo8 !== exp_b) begin
                n_err++;
                $display("FAIL rand8 %h-%h-%0d: got %h/%b lat=%0d early=%b, want %h/%b lat=8",
                         ra[7:0], rb[7:0], rbi, diff8, bo8, lat, early, exp_d, exp_b);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back4();
        int gap;
        logic to;
        logic [3:0] exp_d;
        logic exp_b;
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i[8:5]); b4 = 4'(i[4:1]); bin4 = i[0];
            exp_d = 4'(ref_diff(int'(a4), int'(b4), int'(bin4), 4));
            exp_b = 1'(ref_bout(int'(a4), int'(b4), int'(bin4)));
            gap = 0; to = 1'b1;
            for (int c = 0; c < 20; c++) begin
                tick();
                gap++;
                if (done4) begin
                    to = 1'b0;
                    break;
                end
            end
            if (i == 511) start4 = 1'b0;
            n_cmp++;
            if (to || diff4 !== exp_d || bo4 !== exp_b) begin
                n_err++;
                $display("FAIL sweep4 op%0d: got %h/%b timeout=%b, want %h/%b", i, diff4, bo4, to, exp_d, exp_b);
            end
            if (i > 0) begin
                n_cmp++;
                if (gap != 6) begin
                    n_err++;
                    $display("FAIL sweep4_gap op%0d: got %0d, want 6", i, gap);
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_width2();
        int lat;
        logic to;
        a2 = 2'b01; b2 = 2'b10; bin2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0; to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (done2) begin
                to = 1'b0;
                break;
            end
            tick();
            lat++;
        end
        n_cmp++;
        if (to || lat != 2 || diff2 !== 2'b10 || bo2 !== 1'b1) begin
            n_err++;
            $display("FAIL width2: got %b/%b lat=%0d timeout=%b, want 10/1 lat=2", diff2, bo2, lat, to);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_reset_mid_shift();
        test_random8();
        test_back_to_back4();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
